mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
//  Sits directly upstream of the GPU memory controller.
//  - Arbitrates round-robin among per-core load/store units and latches the winning warp-wide request.
//  - Classifies it (adjacent / off-axis / non-adjacent) and queues the descriptor for the controller.
//  - Routes controller responses back to the originating core.
// PARAMETERS
//  NUM_CORES   4   requesting cores (>=2)
//  LANES       8   lanes per request (power of 2)
//  ADDR_W      32  word-address width
//  DATA_W      32  per-lane data width
//  FIFO_DEPTH  4   descriptor queue depth (power of 2)
// PORTS
//  clk        in   1                        clock
//  reset      in   1                        synchronous, active-high
//  req_valid  in   NUM_CORES                per-core request valid
//  req_ready  out  NUM_CORES                per-core accept (one-hot or zero)
//  req_write  in   NUM_CORES                1=store, 0=load
//  req_shared in   NUM_CORES                1=shared mem, 0=global
//  req_addr   in   NUM_CORES*LANES*ADDR_W   lane addresses
//  req_wdata  in   NUM_CORES*LANES*DATA_W   lane store data
//  out_valid  out  1                        descriptor at FIFO head
//  out_ready  in   1                        controller pops head
//  out_desc   out  $bits(mem_req_t)         {core_id,write,shared,adjacent,offaxis,addr[],wdata[]}
//  rsp_valid  in   1                        controller response valid
//  rsp_core   in   $clog2(NUM_CORES)        response destination
//  rsp_rdata  in   LANES*DATA_W             response data
//  core_rsp_valid out NUM_CORES             registered one-hot response strobe
//  core_rsp_rdata out LANES*DATA_W          registered response data (broadcast)
//  perf_adj, perf_nonadj, perf_stall  out 32 each   performance counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: req_ready=0, out_valid=0, core_rsp_valid=0, core_rsp_rdata=0, FIFO empty, stage S1 empty,
//   rr_ptr=0, counters=0. Reset mid-operation drops S1 and all queued descriptors; cores reissue.
//  Stage FSM (s1_state_t): S1_EMPTY / S1_FULL.
//  - EMPTY -> FULL on a grant.
//  - FULL -> EMPTY when S1 is written to the FIFO and there is no new grant.
//  - FULL stays FULL when S1 is written and a new grant lands in the same cycle.
//  S1 drains into the FIFO when fifo_count<FIFO_DEPTH, or when FIFO is full and out_ready&out_valid that same cycle.
//  Grant enable = S1 empty, or S1 drains this cycle.
//  Grant selection: first valid core starting at rr_ptr, increasing mod NUM_CORES.
//   req_ready is combinational from req_valid/state.
//  On grant to core c: rr_ptr <= (c+1) mod NUM_CORES. No grant: rr_ptr holds.
//  Classification (combinational on S1, stored into FIFO):
//  - adjacent = 1 iff for all lanes i, addr[i] == addr[0]+i, computed at ADDR_W+1 bits.
//    Carry past 2^ADDR_W-1 => adjacent=0.
//  - offaxis = adjacent & (addr[0][log2(LANES)-1:0] != 0).
//  Latency: accept at edge T -> out_valid=1 after edge T+1 (2 cycles) when FIFO is empty.
//  FIFO: pop on out_valid&out_ready; push+pop while full is legal, count unchanged.
//   Pointers wrap mod FIFO_DEPTH. out_desc is undefined when out_valid=0.
//  Response: core_rsp_valid <= onehot(rsp_core) & {NUM_CORES{rsp_valid}}; 1-cycle latency.
//   rsp_core>=NUM_CORES => no strobe.
// CONFIGURATION
//  MEM_ARB_PERF_CNT_EN defined: 32-bit saturating counters (stick at 0xFFFFFFFF).
//  - perf_adj: +1 per push with adjacent=1.
//  - perf_nonadj: +1 per push with adjacent=0.
//  - perf_stall: +1 per cycle with |req_valid and no grant.
//  MEM_ARB_PERF_CNT_EN undefined: perf_* tied to 0, no counter flops.
// STRUCTURE
//  gpuCoreTypes package gets:
//  - typedef struct packed mem_req_t (descriptor fields above)
//  - typedef enum s1_state_t
//  - localparam-free helper function is_adjacent()
//  Sub-module desc_fifo (parameterised DEPTH, type mem_req_t; count, full/empty).
//  Arbiter, S1 and response router stay inline.
// TESTING
//  1 core0, addr 0x100..0x107, out_ready=1 -> out_valid 2 cycles later; adjacent=1, offaxis=0, core_id=0.
//  2 core2, addr 0x103..0x10A -> adjacent=1, offaxis=1.
//  3 core1, lane5=0x200 else consecutive from 0x100 -> adjacent=0, offaxis=0.
//  4 base 0xFFFFFFFE consecutive -> adjacent=0 (wrap).
//  5 all cores valid continuously, out_ready=1 -> grants 0,1,2,3,0,... one per cycle, no bubbles.
//  6 out_ready=0, core0 streams -> 5 accepts (4 FIFO + S1), then req_ready=0.
//    One pop -> exactly one more accept. perf_stall increments while blocked (macro on).
//  7 reset asserted with 3 queued -> next cycle out_valid=0, rr_ptr=0, counters=0.
//  8 rsp_valid, rsp_core=3, rdata=0xA5.. -> core_rsp_valid=4'b1000 one cycle later, data matches.

Source files
------------

// File: rtl/mem_request_arbiter_pkg.sv
// Shared types for the memory request arbiter: descriptor layout, S1 stage state, adjacency check.
// Latency: none (types and pure functions only). Backpressure: n/a.
package gpuCoreTypes;

    localparam int CFG_NUM_CORES = 4;
    localparam int CFG_LANES     = 8;
    localparam int CFG_ADDR_W    = 32;
    localparam int CFG_DATA_W    = 32;
    localparam int CFG_CORE_W    = $clog2(CFG_NUM_CORES);

    typedef struct packed {
        logic [CFG_CORE_W-1:0]                 core_id;
        logic                                  write;
        logic                                  shared;
        logic                                  adjacent;
        logic                                  offaxis;
        logic [CFG_LANES-1:0][CFG_ADDR_W-1:0]  addr;
        logic [CFG_LANES-1:0][CFG_DATA_W-1:0]  wdata;
    } mem_req_t;

    typedef enum logic [0:0] {
        S1_EMPTY = 1'b0,
        S1_FULL  = 1'b1
    } s1_state_t;

    // One extra bit so a run that carries past the top of the address space never matches.
    function automatic logic is_adjacent(input logic [CFG_LANES-1:0][CFG_ADDR_W-1:0] addr);
        logic                  r_ok;
        logic [CFG_ADDR_W:0]   w_exp;
        r_ok  = 1'b1;
        w_exp = '0;
        for (int i = 0; i < CFG_LANES; i++) begin
            w_exp = {1'b0, addr[0]} + (CFG_ADDR_W+1)'(i);
            if ({1'b0, addr[i]} != w_exp) begin
                r_ok = 1'b0;
            end
        end
        return r_ok;
    endfunction

endpackage

// File: rtl/mem_request_arbiter_desc_fifo.sv
// Descriptor queue between S1 and the memory controller, power-of-2 depth.
// Latency: push visible at head the cycle after the write edge. Backpressure: push ignored when full unless popping.
module desc_fifo
    import gpuCoreTypes::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = mem_req_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_dat,
    input  logic                   pop,
    output T                       pop_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign empty   = (r_count == '0);
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign count   = r_count;
    assign pop_dat = r_mem[r_rptr];
    assign w_pop   = pop & ~empty;
    assign w_push  = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= push_dat;
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter over per-core LSUs feeding a classified descriptor queue; routes responses back.
// Latency: grant edge -> out_valid two edges later; response strobe one cycle. Backpressure: req_ready drops when S1 and FIFO are full.
// Optional MEM_ARB_PERF_CNT_EN adds saturating perf counters; otherwise perf_* are tied to zero.
module mem_request_arbiter
    import gpuCoreTypes::*;
#(
    parameter int NUM_CORES  = CFG_NUM_CORES,
    parameter int LANES      = CFG_LANES,
    parameter int ADDR_W     = CFG_ADDR_W,
    parameter int DATA_W     = CFG_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CORES-1:0]              req_valid,
    output logic [NUM_CORES-1:0]              req_ready,
    input  logic [NUM_CORES-1:0]              req_write,
    input  logic [NUM_CORES-1:0]              req_shared,
    input  logic [NUM_CORES*LANES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*LANES*DATA_W-1:0] req_wdata,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$bits(mem_req_t)-1:0]       out_desc,
    input  logic                              rsp_valid,
    input  logic [$clog2(NUM_CORES)-1:0]      rsp_core,
    input  logic [LANES*DATA_W-1:0]           rsp_rdata,
    output logic [NUM_CORES-1:0]              core_rsp_valid,
    output logic [LANES*DATA_W-1:0]           core_rsp_rdata,
    output logic [31:0]                       perf_adj,
    output logic [31:0]                       perf_nonadj,
    output logic [31:0]                       perf_stall
);
    localparam int CW = $clog2(NUM_CORES);

    s1_state_t                r_s1_state;
    mem_req_t                 r_s1;
    logic [CW-1:0]            r_rr_ptr;
    logic [NUM_CORES-1:0]     r_rsp_vld;
    logic [LANES*DATA_W-1:0]  r_rsp_dat;

    logic [NUM_CORES-1:0]     w_grant_oh;
    logic [CW-1:0]            w_grant_idx;
    logic                     w_grant_any;
    logic                     w_grant_en;
    logic                     w_grant;
    logic                     w_drain;
    logic                     w_pop;
    logic                     w_s1_adj;
    logic                     w_s1_off;
    mem_req_t                 w_push_desc;
    mem_req_t                 w_head;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [NUM_CORES-1:0]     w_rsp_oh;

    assign out_valid = ~w_fifo_empty;
    assign out_desc  = w_head;
    assign w_pop     = out_valid & out_ready;
    assign w_drain   = (r_s1_state == S1_FULL) &&
                       ((int'(w_fifo_count) < FIFO_DEPTH) || (w_fifo_full && w_pop));
    assign w_grant_en = (r_s1_state == S1_EMPTY) || w_drain;
    assign w_grant    = w_grant_en & w_grant_any & ~reset;
    assign req_ready  = w_grant ? w_grant_oh : '0;

    always_comb begin
        int idx;
        idx         = 0;
        w_grant_oh  = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_CORES;
            if (!w_grant_any && req_valid[idx]) begin
                w_grant_any     = 1'b1;
                w_grant_idx     = CW'(idx);
                w_grant_oh[idx] = 1'b1;
            end
        end
    end

    assign w_s1_adj = is_adjacent(r_s1.addr);
    assign w_s1_off = w_s1_adj && (r_s1.addr[0][$clog2(LANES)-1:0] != '0);

    always_comb begin
        w_push_desc          = r_s1;
        w_push_desc.adjacent = w_s1_adj;
        w_push_desc.offaxis  = w_s1_off;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_state <= S1_EMPTY;
            r_rr_ptr   <= '0;
        end else begin
            if (w_grant) begin
                r_s1_state <= S1_FULL;
                r_rr_ptr   <= CW'((int'(w_grant_idx) + 1) % NUM_CORES);
            end else if (w_drain) begin
                r_s1_state <= S1_EMPTY;
            end
        end
    end

    // Payload needs no reset: it is only observed once r_s1_state says it is valid.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_s1.core_id  <= w_grant_idx;
            r_s1.write    <= req_write[w_grant_idx];
            r_s1.shared   <= req_shared[w_grant_idx];
            r_s1.adjacent <= 1'b0;
            r_s1.offaxis  <= 1'b0;
            r_s1.addr     <= req_addr[int'(w_grant_idx)*LANES*ADDR_W +: LANES*ADDR_W];
            r_s1.wdata    <= req_wdata[int'(w_grant_idx)*LANES*DATA_W +: LANES*DATA_W];
        end
    end

    desc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (mem_req_t)
    ) u_desc_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_drain),
        .push_dat (w_push_desc),
        .pop      (w_pop),
        .pop_dat  (w_head),
        .count    (w_fifo_count),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

    always_comb begin
        w_rsp_oh = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_rsp_oh[c] = rsp_valid && (int'(rsp_core) == c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_vld <= '0;
            r_rsp_dat <= '0;
        end else begin
            r_rsp_vld <= w_rsp_oh;
            if (rsp_valid) r_rsp_dat <= rsp_rdata;
        end
    end

    assign core_rsp_valid = r_rsp_vld;
    assign core_rsp_rdata = r_rsp_dat;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_adj;
    logic [31:0] r_perf_nonadj;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_adj    <= '0;
            r_perf_nonadj <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_drain && w_s1_adj && (r_perf_adj != '1))     r_perf_adj    <= r_perf_adj + 1'b1;
            if (w_drain && !w_s1_adj && (r_perf_nonadj != '1)) r_perf_nonadj <= r_perf_nonadj + 1'b1;
            if ((|req_valid) && !w_grant && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_adj    = r_perf_adj;
    assign perf_nonadj = r_perf_nonadj;
    assign perf_stall  = r_perf_stall;
`else
    assign perf_adj    = '0;
    assign perf_nonadj = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed self-checking bench for mem_request_arbiter: reset, classification, round-robin, backpressure, responses.
module tb_mem_request_arbiter;
    import gpuCoreTypes::*;

    localparam int NC = 4;
    localparam int L  = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NC-1:0]            req_valid;
    logic [NC-1:0]            req_ready;
    logic [NC-1:0]            req_write;
    logic [NC-1:0]            req_shared;
    logic [NC*L*AW-1:0]       req_addr;
    logic [NC*L*DW-1:0]       req_wdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [$bits(mem_req_t)-1:0] out_desc;
    logic                     rsp_valid;
    logic [1:0]               rsp_core;
    logic [L*DW-1:0]          rsp_rdata;
    logic [NC-1:0]            core_rsp_valid;
    logic [L*DW-1:0]          core_rsp_rdata;
    logic [31:0]              perf_adj;
    logic [31:0]              perf_nonadj;
    logic [31:0]              perf_stall;

    mem_req_t d;
    assign d = mem_req_t'(out_desc);

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_request_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_shared     (req_shared),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_desc       (out_desc),
        .rsp_valid      (rsp_valid),
        .rsp_core       (rsp_core),
        .rsp_rdata      (rsp_rdata),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_rdata (core_rsp_rdata),
        .perf_adj       (perf_adj),
        .perf_nonadj    (perf_nonadj),
        .perf_stall     (perf_stall)
    );

    task automatic load_core(input int c, input logic [31:0] base, input int bad_lane, input logic [31:0] bad_addr);
        for (int i = 0; i < L; i++) begin
            req_addr[(c*L+i)*AW +: AW]  = (i == bad_lane) ? bad_addr : base + 32'(i);
            req_wdata[(c*L+i)*DW +: DW] = 32'hD000_0000 + 32'(c*16 + i);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_write = '0; req_shared = '0;
        req_addr = '0; req_wdata = '0; out_ready = 1'b0;
        rsp_valid = 1'b0; rsp_core = '0; rsp_rdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (core_rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", core_rsp_valid); end
        checks++; if (core_rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", core_rsp_rdata); end
        checks++; if ({perf_adj, perf_nonadj, perf_stall} !== 96'd0) begin errors++; $display("FAIL reset_perf: got %h/%h/%h expected 0", perf_adj, perf_nonadj, perf_stall); end
        reset = 1'b0;
    endtask

    // core, base, corrupted lane (-1 none), corrupted address, write, shared, expected adjacent/offaxis
    task automatic test_classify();
        int          tc_core [4] = '{0, 2, 1, 3};
        logic [31:0] tc_base [4] = '{32'h100, 32'h103, 32'h100, 32'hFFFF_FFFE};
        int          tc_bad  [4] = '{-1, -1, 5, -1};
        logic        tc_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        tc_sh   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        tc_adj  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        tc_off  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_l7;
        logic [31:0] exp_l5;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            load_core(tc_core[t], tc_base[t], tc_bad[t], 32'h200);
            req_write  = '0; req_write[tc_core[t]]  = tc_wr[t];
            req_shared = '0; req_shared[tc_core[t]] = tc_sh[t];
            req_valid  = '0; req_valid[tc_core[t]]  = 1'b1;
            out_ready  = 1'b1;
            exp_l7 = tc_base[t] + 32'd7;
            exp_l5 = (tc_bad[t] == 5) ? 32'h200 : tc_base[t] + 32'd5;
            #1;
            checks++; if (req_ready !== (4'b0001 << tc_core[t])) begin errors++; $display("FAIL cls%0d_ready: got %b expected %b", t, req_ready, 4'b0001 << tc_core[t]); end
            @(negedge clk);
            req_valid = '0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cls%0d_early_valid: got %b expected 0", t, out_valid); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cls%0d_out_valid: got %b expected 1", t, out_valid); end
            checks++; if (d.core_id !== 2'(tc_core[t])) begin errors++; $display("FAIL cls%0d_core_id: got %0d expected %0d", t, d.core_id, tc_core[t]); end
            checks++; if (d.adjacent !== tc_adj[t]) begin errors++; $display("FAIL cls%0d_adjacent: got %b expected %b", t, d.adjacent, tc_adj[t]); end
            checks++; if (d.offaxis !== tc_off[t]) begin errors++; $display("FAIL cls%0d_offaxis: got %b expected %b", t, d.offaxis, tc_off[t]); end
            checks++; if ({d.write, d.shared} !== {tc_wr[t], tc_sh[t]}) begin errors++; $display("FAIL cls%0d_wr_sh: got %b%b expected %b%b", t, d.write, d.shared, tc_wr[t], tc_sh[t]); end
            checks++; if (d.addr[7] !== exp_l7 || d.addr[5] !== exp_l5) begin errors++; $display("FAIL cls%0d_addr: got %h/%h expected %h/%h", t, d.addr[7], d.addr[5], exp_l7, exp_l5); end
            checks++; if (d.wdata[2] !== 32'hD000_0000 + 32'(tc_core[t]*16 + 2)) begin errors++; $display("FAIL cls%0d_wdata: got %h expected %h", t, d.wdata[2], 32'hD000_0000 + 32'(tc_core[t]*16 + 2)); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cls%0d_popped: got %b expected 0", t, out_valid); end
        end
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < NC; c++) load_core(c, 32'h1000 * (c + 1), -1, 32'h0);
        req_valid = '1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, 4'b0001 << (k % 4)); end
            @(negedge clk);
            if (k >= 1) begin
                checks++; if (out_valid !== 1'b1 || d.core_id !== 2'((k - 1) % 4)) begin errors++; $display("FAIL rr_head%0d: got v=%b id=%0d expected v=1 id=%0d", k, out_valid, d.core_id, (k - 1) % 4); end
            end
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int          accepts;
        logic [31:0] p0;
        accepts = 0;
        out_ready = 1'b0; req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_ready[0] === 1'b1) accepts++;
            @(negedge clk);
        end
        checks++; if (accepts !== 5) begin errors++; $display("FAIL bp_accepts: got %0d expected 5", accepts); end
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_blocked: got %b expected 0000", req_ready); end
        p0 = perf_stall;
        repeat (3) @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
        checks++; if (perf_stall !== p0 + 32'd3) begin errors++; $display("FAIL bp_perf_stall: got %0d expected %0d", perf_stall, p0 + 32'd3); end
`else
        checks++; if (perf_stall !== 32'd0) begin errors++; $display("FAIL bp_perf_stall: got %0d expected 0", perf_stall); end
`endif
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_pop_accept: got %b expected 0001", req_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_one_only: got %b expected 0000", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_still_full: got ready=%b v=%b expected 0000/1", req_ready, out_valid); end
    endtask

    task automatic test_reset_midop();
        req_valid = '1; reset = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        checks++; if ({perf_adj, perf_nonadj, perf_stall} !== 96'd0) begin errors++; $display("FAIL rst_mid_perf: got %h/%h/%h expected 0", perf_adj, perf_nonadj, perf_stall); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_rr_ptr: got %b expected 0001", req_ready); end
        req_valid = '0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_response();
        logic [L*DW-1:0] pat;
        pat = {L{32'hA5A5_A5A5}};
        rsp_valid = 1'b1; rsp_core = 2'd3; rsp_rdata = pat;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_rdata = '0;
        checks++; if (core_rsp_valid !== 4'b1000) begin errors++; $display("FAIL rsp3_valid: got %b expected 1000", core_rsp_valid); end
        checks++; if (core_rsp_rdata !== pat) begin errors++; $display("FAIL rsp3_rdata: got %h expected %h", core_rsp_rdata, pat); end
        @(negedge clk);
        checks++; if (core_rsp_valid !== 4'b0000) begin errors++; $display("FAIL rsp3_clear: got %b expected 0000", core_rsp_valid); end
        pat = {L{32'h5A5A_0001}};
        rsp_valid = 1'b1; rsp_core = 2'd0; rsp_rdata = pat;
        @(negedge clk);
        rsp_valid = 1'b0;
        checks++; if (core_rsp_valid !== 4'b0001 || core_rsp_rdata !== pat) begin errors++; $display("FAIL rsp0: got %b/%h expected 0001/%h", core_rsp_valid, core_rsp_rdata, pat); end
    endtask

    initial begin
        test_reset();
        test_classify();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_response();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
